// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding, debounce defaults and counter sizing for the IN/OUT controller
package io_pkg;

   typedef enum logic [1:0] {
      IO_IDLE         = 2'd0,
      IO_WAIT_PRESS   = 2'd1,
      IO_WAIT_RELEASE = 2'd2
   } io_state_t;

   localparam int DEBOUNCE_SIM   = 4;
   localparam int DEBOUNCE_BOARD = 500000;

   // Enough bits to hold the saturated count value itself.
   function automatic int cnt_width(input int debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - button synchroniser with saturating stable-level counter
module button_debouncer
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button,
   input  logic clear,
   input  logic expect_level,
   output logic stable
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          btn_meta;
   logic          btn_s;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous push button.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= button;
         btn_s    <= btn_meta;
      end
   end

   // Count consecutive samples at the expected level; any other sample or a state change restarts it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear || (btn_s != expect_level)) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The sample that completes the run is the current one, so stable fires one count early.
   always_comb begin
      stable = (btn_s == expect_level) && (cnt == CNT_LAST);
   end

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - sequences CPU IN/OUT against button, switches and display register
module io_controller
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
   parameter int SWITCH_WIDTH    = 18,
   parameter int OUT_WIDTH       = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_request,
   input  logic                    out_request,
   input  logic [OUT_WIDTH-1:0]    out_data,
   input  logic                    button,
   input  logic [SWITCH_WIDTH-1:0] switches,
   output logic                    halt,
   output logic [SWITCH_WIDTH-1:0] in_data,
   output logic                    in_valid,
   output logic [OUT_WIDTH-1:0]    display_value,
   output logic                    display_valid
);

   io_state_t state;
   io_state_t state_next;
   logic      stable;
   logic      expect_level;
   logic      clear;
   logic      capture;
   logic      req_eff;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clock       (clock),
      .reset_n     (reset_n),
      .button      (button),
      .clear       (clear),
      .expect_level(expect_level),
      .stable      (stable)
   );

   // State register; reset lands in WAIT_RELEASE so a button held through reset is not a press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IO_WAIT_RELEASE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, capture strobe and CPU stall.
   always_comb begin
      state_next   = state;
      capture      = 1'b0;
      halt         = 1'b0;
      expect_level = 1'b0;
      // The request seen in the capture cycle has already been served.
      req_eff      = in_request && !in_valid;
      case (state)
         IO_IDLE: begin
            halt = in_request;
            if (in_request) begin
               state_next = IO_WAIT_PRESS;
            end
         end
         IO_WAIT_PRESS: begin
            halt         = 1'b1;
            expect_level = 1'b1;
            if (stable) begin
               capture    = 1'b1;
               state_next = IO_WAIT_RELEASE;
            end
         end
         IO_WAIT_RELEASE: begin
            halt = req_eff;
            if (stable) begin
               state_next = req_eff ? IO_WAIT_PRESS : IO_IDLE;
            end
         end
         default: begin
            state_next = IO_WAIT_RELEASE;
         end
      endcase
      // A reset also resets the CPU, so the stall must drop at once.
      if (!reset_n) begin
         halt = 1'b0;
      end
      clear = (state_next != state);
   end

   // Capture the switches on an accepted press; in_valid is a single-cycle pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_data  <= '0;
         in_valid <= 1'b0;
      end else begin
         in_valid <= capture;
         if (capture) begin
            in_data <= switches;
         end
      end
   end

   // Display register, independent of the IN sequencing and never stalling.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         display_value <= '0;
         display_valid <= 1'b0;
      end else if (out_request) begin
         display_value <= out_data;
         display_valid <= 1'b1;
      end
   end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Sequences the processor's IN/OUT instructions against the board's button, switches and display register.
- For IN: stalls the CPU with halt until one debounced button press occurs, captures the switches, and returns them to the datapath.
- Blocks re-use of the same press until the button has been debounced-released.
- For OUT: latches CPU data into the display register without stalling.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a press/release (must be >=1; board build uses 500000).
- SWITCH_WIDTH, 18, width of switches and in_data.
- OUT_WIDTH, 32, width of out_data and display_value.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_request  input  1  level; CPU executing IN, held until in_valid seen.
- out_request  input  1  one-cycle pulse; CPU executing OUT.
- out_data  input  OUT_WIDTH  value to display, sampled when out_request=1.
- button  input  1  raw asynchronous push button, 1=pressed.
- switches  input  SWITCH_WIDTH  raw switch levels.
- halt  output  1  stall to CPU (combinational from state and in_request).
- in_data  output  SWITCH_WIDTH  captured switches.
- in_valid  output  1  registered one-cycle pulse, in_data valid.
- display_value  output  OUT_WIDTH  latched OUT value.
- display_valid  output  1  sticky: at least one OUT since reset.

Behaviour:
- Reset (async, reset_n=0):
  - in_data=0, in_valid=0, display_value=0, display_valid=0.
  - Synchroniser flops=0, debounce counter=0, state=WAIT_RELEASE.
  - Starting in WAIT_RELEASE means a button held through reset is never taken as a press.
  - Reset mid-IN drops halt immediately; the pending IN is lost and the CPU is reset with it.
- Synchroniser: button passes through a 2-flop synchroniser (btn_s). switches are sampled directly at capture; they are assumed quasi-static.
- Debounce counter:
  - Width clog2(DEBOUNCE_CYCLES+1).
  - Cleared on every state change.
  - In WAIT_PRESS, clears when btn_s=0. In WAIT_RELEASE, clears when btn_s=1.
  - Otherwise increments, saturating at DEBOUNCE_CYCLES.
- FSM states:
  - IDLE (button debounced-released).
    - in_request=1 -> WAIT_PRESS.
    - halt = in_request.
  - WAIT_PRESS (halt=1).
    - When btn_s=1 and counter==DEBOUNCE_CYCLES-1: in_data<=switches, in_valid<=1 on the same edge, -> WAIT_RELEASE.
  - WAIT_RELEASE (waiting for release).
    - In the first cycle (in_valid=1), halt=0 regardless of in_request; that cycle's request is consumed.
    - Afterwards halt = in_request (a new IN stalls until release and a fresh press).
    - When btn_s=0 and counter==DEBOUNCE_CYCLES-1: go to WAIT_PRESS if in_request=1, else IDLE.
- in_valid is high exactly one cycle per accepted press.
- Press latency: the first rising edge at which btn_s=1 is edge e; in_valid is high in the cycle after edge e+DEBOUNCE_CYCLES-1, provided the button stays high. A raw button=1 reaches btn_s after 2 edges.
- Glitches: any btn_s bounce shorter than DEBOUNCE_CYCLES samples clears the counter and never produces a capture.
- Output path (independent of the FSM):
  - out_request=1 -> display_value<=out_data, display_valid<=1 on that edge.
  - Never stalls; accepted in any state, including while halt=1.
  - Simultaneous with an IN capture: both complete on the same edge.
  - Back-to-back pulses: last value wins.
- Halt never depends on out_request.

Decomposition:
- Shared package io_pkg holds:
  - the state encoding (IO_IDLE=2'd0, IO_WAIT_PRESS=2'd1, IO_WAIT_RELEASE=2'd2);
  - the DEBOUNCE_CYCLES simulation and board defaults;
  - the counter width function.
- One sub-module, button_debouncer: synchroniser plus counter.
  - Ports: clock, reset_n, button, clear, expect_level, stable.
  - stable pulses when counter==DEBOUNCE_CYCLES-1 with btn_s==expect_level.
  - The FSM and output register remain in io_controller.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with button=1 held, then in_request=1 -> halt=1. Release button for 6 cycles, then press with switches=18'h2A5A5 -> in_valid single pulse, in_data=18'h2A5A5, halt=0 that cycle.
- Button bounce 1,0,1,1,0 (each 1 cycle) while in WAIT_PRESS -> no in_valid, halt stays 1. Then hold 1 for 6 cycles -> exactly one capture, at the latency stated above.
- Capture done, button still held, CPU raises in_request again -> halt=1 with no second capture. Release for 4+ synchronised cycles, then press with switches=18'h00011 -> in_data=18'h00011.
- out_request pulse with out_data=32'hDEADBEEF while halt=1 -> display_value=32'hDEADBEEF and display_valid=1 next cycle, halt unchanged. A second pulse with 32'h1 -> display_value=32'h1.
- out_request on the same edge as a capture -> both display_value and in_data update; in_valid=1.
- reset_n low mid WAIT_PRESS -> halt=0 and all outputs zero asynchronously (before the next clock edge). After release, a held button produces no capture until it is released and pressed again.
